// File: rtl/pingpong_pkg.sv
// Constants and helpers shared by the ping-pong buffer family.
// Bank-state encoding lives here so every buffer agrees on what "committed" means.
package pingpong_pkg;

   localparam int NUM_BANKS = 2;

   typedef enum logic {
      BANK_FREE      = 1'b0,
      BANK_COMMITTED = 1'b1
   } bank_state_e;

   // Address width for a given depth, never narrower than one bit.
   function automatic int clog2_safe(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/bram_bank_1w1r.sv
// Single bank of block RAM: one write port, one registered read port.
// The read register only updates on a read strobe, so its output holds between reads.
module bram_bank_1w1r
   import pingpong_pkg::*;
#(
   parameter int DATA_WIDTH = 4096,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = clog2_safe(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // NOTE: the array has no reset; a reset term would stop it mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we && (32'(i_waddr) < DEPTH)) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re && (32'(i_raddr) < DEPTH)) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pingpong_tile_buf.sv
// Two-bank ping-pong tile buffer: the writer fills one bank while the reader drains the other,
// with bank ownership handed over by commit (wr_done) and release (rd_done).
module pingpong_tile_buf
   import pingpong_pkg::*;
#(
   parameter  int DATA_WIDTH = 4096,
   parameter  int DEPTH      = 64,
   localparam int ADDR_W     = clog2_safe(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_done,
   output logic                  wr_ready,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   input  logic                  rd_done,
   output logic                  rd_bank_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_data_valid,
   output logic [1:0]            banks_full
);

   logic [NUM_BANKS-1:0] r_full;
   logic                 r_wbank;
   logic                 r_rbank;
   logic                 r_rd_sel;
   logic                 r_rd_seen;
   logic                 r_rd_data_valid;

   logic                  w_wr_acc;
   logic                  w_commit;
   logic                  w_rd_acc;
   logic                  w_release;
   logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

   assign wr_ready      = ~r_full[r_wbank];
   assign rd_bank_valid = r_full[r_rbank];
   assign banks_full    = 2'(r_full[0]) + 2'(r_full[1]);

   assign w_wr_acc  = wr_en   & wr_ready;
   assign w_commit  = wr_done & wr_ready;
   assign w_rd_acc  = rd_en   & rd_bank_valid;
   assign w_release = rd_done & rd_bank_valid;

   // Commit and release can never target the same bank (commit needs it free, release needs it
   // committed), so both updates to r_full are safe in one cycle.
   // NOTE: non-blocking assignments keep every update reading pre-edge state, which is what
   // lets a same-cycle write+commit land in the old bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_full          <= '0;
         r_wbank         <= 1'b0;
         r_rbank         <= 1'b0;
         r_rd_sel        <= 1'b0;
         r_rd_seen       <= 1'b0;
         r_rd_data_valid <= 1'b0;
      end else begin
         if (w_commit) begin
            r_full[r_wbank] <= BANK_COMMITTED;
            r_wbank         <= ~r_wbank;
         end
         if (w_release) begin
            r_full[r_rbank] <= BANK_FREE;
            r_rbank         <= ~r_rbank;
         end
         r_rd_data_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_sel  <= r_rbank;
            r_rd_seen <= 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      bram_bank_1w1r #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .ADDR_W     (ADDR_W)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_wr_acc && (r_wbank == 1'(b))),
         .i_waddr (wr_addr),
         .i_wdata (wr_data),
         .i_re    (w_rd_acc && (r_rbank == 1'(b))),
         .i_raddr (rd_addr),
         .o_rdata (w_bank_rdata[b])
      );
   end

   // Bank read registers hold between reads; the gate forces zero until the first read after reset.
   assign rd_data       = r_rd_seen ? w_bank_rdata[r_rd_sel] : '0;
   assign rd_data_valid = r_rd_data_valid;

endmodule

// File: doc/pingpong_tile_buf.md
Name: pingpong_tile_buf

Overview:
- Two-bank ping-pong tile buffer for the matrix-multiply datapath.
- A producer (MAC array result writer) fills one bank while a consumer (next layer / output streamer) drains the other.
- Bank ownership is passed by commit/release handshakes.
- Each bank is a simple one-write/one-read BRAM, so fill and drain run concurrently without address collisions.

Parameters:
- DATA_WIDTH, 4096, bits per word.
- DEPTH, 64, words per bank; need not be a power of two; must be >= 1.
- ADDR_W, clog2 of DEPTH with a minimum of 1, address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write strobe into the current write bank.
- wr_addr  in  ADDR_W  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_done  in  1  commit current write bank to the reader.
- wr_ready  out  1  current write bank is free (writes and commit accepted).
- rd_en  in  1  read strobe from the current read bank.
- rd_addr  in  ADDR_W  read word address.
- rd_done  in  1  release current read bank back to the writer.
- rd_bank_valid  out  1  current read bank holds committed data.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_data_valid  out  1  rd_data carries the result of a read issued last cycle.
- banks_full  out  2  number of committed banks, 0..2.

Behaviour:
State:
- full[1:0]: per-bank committed flags.
- wbank, rbank: 1-bit bank pointers.

Reset (rst_n=0 at a clk edge):
- full=0, wbank=0, rbank=0.
- rd_data=0, rd_data_valid=0.
- Resulting outputs: wr_ready=1, rd_bank_valid=0, banks_full=0.
- Memory contents are not cleared (BRAM inference) and are undefined after reset.
- Reset mid-operation discards any in-flight read: rd_data_valid=0 the cycle after reset.

Combinational outputs:
- wr_ready = ~full[wbank].
- rd_bank_valid = full[rbank].
- banks_full = full[0]+full[1].

Write side:
- Accepted when wr_en & wr_ready: mem[wbank][wr_addr] <= wr_data.
- wr_en with wr_ready=0 is ignored; no state change.
- wr_addr >= DEPTH: write dropped.
- wr_done & wr_ready: full[wbank] <= 1, wbank toggles.
- wr_done with wr_ready=0 is ignored.
- wr_en & wr_done in the same cycle: the write lands in the old bank, then the commit takes effect.

Read side:
- Accepted when rd_en & rd_bank_valid: rd_data <= mem[rbank][rd_addr] one cycle later, with rd_data_valid=1 in that cycle.
- Latency is exactly 1 cycle; one read per cycle, fully pipelined.
- rd_en with rd_bank_valid=0 is ignored: rd_data_valid=0 next cycle, rd_data holds.
- rd_data holds its last value whenever rd_data_valid=0.
- rd_addr >= DEPTH: rd_data_valid still asserts; data is unspecified.
- rd_done & rd_bank_valid: full[rbank] <= 0, rbank toggles.
- rd_done with rd_bank_valid=0 is ignored.
- rd_en & rd_done in the same cycle: the read is taken from the old bank and its data returns valid next cycle.

Simultaneous events:
- wr_done and rd_done in the same cycle always target different banks, since commit needs full=0 and release needs full=1. Both take effect.
- A same-bank read and write in the same cycle cannot occur, so read-during-write behaviour is irrelevant.

Both banks full:
- wr_ready=0 until the next rd_done.
- The writer must stall; no data is overwritten.

Both banks empty:
- rd_bank_valid=0; the reader must wait.

Decomposition:
- Shared package (pingpong_pkg): NUM_BANKS=2 constant and the clog2_safe function.
- The bank-state constants live in the same package, so other buffers share them.
- Sub-module bram_bank_1w1r holds a single-bank memory: one write port and one registered read port, block-RAM style attribute, no reset on the array.
- Instantiate it twice; write enables are gated by wbank and read enables by rbank.
- The read-data mux is selected by a registered copy of rbank captured at read issue.

Test Plan:
- Reset, then fill bank0 with addr i -> data i+1 for i=0..63, assert wr_done -> wr_ready stays 1, rd_bank_valid=1, banks_full=1. Read addr 5 -> rd_data=6, rd_data_valid=1 exactly one cycle later.
- Fill and commit both banks without any rd_done -> banks_full=2, wr_ready=0. A further wr_en to addr 0 with 0xDEAD is dropped, and a later read of bank0 addr 0 returns 1.
- Concurrency: read bank0 addrs 0..63 back-to-back while writing bank1 with 0x100+i -> 64 consecutive rd_data_valid pulses, data 1..64 in order, no bubbles. Then rd_done and wr_done in the same cycle -> banks_full=1, rd_bank_valid=1, and reading bank1 addr 3 returns 0x103.
- Same-cycle rd_en(addr 63)+rd_done on bank0 -> next cycle rd_data=64, rd_data_valid=1, and rbank has advanced.
- Idle handshakes: rd_en and rd_done with banks_full=0 -> rd_data_valid stays 0, state unchanged. wr_done while wr_ready=0 -> no state change.
- Reset asserted the cycle after an accepted rd_en -> rd_data_valid=0, rd_data=0, banks_full=0, wr_ready=1.
